// File: rtl/signed_seq_divider.sv
// Signed 16/8 sequential restoring divider: one quotient bit per clock,
// magnitudes divided unsigned, then signs and saturation applied in FIX.
module signed_seq_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic [7:0]  quotient,
  output logic [7:0]  remainder,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic        overflow
);

  localparam int unsigned DVD_W = 16;
  localparam int unsigned DVS_W = 8;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             sign_q;
  logic             sign_r;
  logic             dz;
  logic [DVD_W-1:0] dvd;   // dividend magnitude, becomes unsigned quotient
  logic [DVS_W-1:0] dvs;   // divisor magnitude (128 representable)
  logic [DVS_W-1:0] part;  // partial remainder, always below dvs
  logic [CNT_W-1:0] cnt;

  logic [DVD_W-1:0] abs_dividend_c;
  logic [DVS_W-1:0] abs_divisor_c;
  logic [DVS_W:0]   part_shift_c;
  logic [DVS_W:0]   part_sub_c;
  logic             part_ge_c;
  logic             fix_ovf_c;
  logic [7:0]       fix_quot_c;
  logic [7:0]       fix_rem_c;

  // Operand magnitudes; -32768 and -128 map to their unsigned magnitudes.
  always_comb begin
    abs_dividend_c = dividend[DVD_W-1] ? DVD_W'(DVD_W'(0) - dividend) : dividend;
    abs_divisor_c  = divisor[DVS_W-1]  ? DVS_W'(DVS_W'(0) - divisor)  : divisor;
  end

  // One restoring step: shift in next dividend bit, trial-subtract divisor.
  always_comb begin
    part_shift_c = {part, dvd[DVD_W-1]};
    part_ge_c    = (part_shift_c >= {1'b0, dvs});
    part_sub_c   = part_shift_c - {1'b0, dvs};
  end

  // Sign fix-up and saturation of the unsigned result.
  always_comb begin
    fix_ovf_c  = (!sign_q && (dvd > 16'd127)) || (sign_q && (dvd > 16'd128));
    fix_quot_c = sign_q ? 8'(8'd0 - dvd[7:0]) : dvd[7:0];
    if (fix_ovf_c) begin
      fix_quot_c = sign_q ? 8'h80 : 8'h7F;
    end
    fix_rem_c  = sign_r ? 8'(8'd0 - part) : part;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (divisor == 8'd0) ? FIX : ITER;
        end
      end
      ITER: begin
        if (cnt == 4'd15) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dz          <= 1'b0;
      dvd         <= '0;
      dvs         <= '0;
      part        <= '0;
      cnt         <= '0;
      quotient    <= 8'd0;
      remainder   <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign_q <= dividend[DVD_W-1] ^ divisor[DVS_W-1];
            sign_r <= dividend[DVD_W-1];
            dz     <= (divisor == 8'd0);
            dvd    <= abs_dividend_c;
            dvs    <= abs_divisor_c;
            part   <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
          end
        end
        ITER: begin
          part <= part_ge_c ? DVS_W'(part_sub_c) : DVS_W'(part_shift_c);
          dvd  <= {dvd[DVD_W-2:0], part_ge_c};
          cnt  <= CNT_W'(cnt + 4'd1);
        end
        FIX: begin
          done        <= 1'b1;
          busy        <= 1'b0;
          div_by_zero <= dz;
          if (dz) begin
            quotient  <= 8'd0;
            remainder <= 8'd0;
            overflow  <= 1'b0;
          end else begin
            quotient  <= fix_quot_c;
            remainder <= fix_rem_c;
            overflow  <= fix_ovf_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
